// File: rtl/rv32_pkg.sv
// rv32_pkg: definitions shared across the RV32IM pipeline slice.
//   - XLEN / REG_W: datapath and register-index widths.
//   - load_f3_e: funct3 encodings of the load instructions.
//   - MD_ENTRY_W: width of one buffered mul/div result ({rd, data}).
package rv32_pkg;

  localparam int XLEN       = 32;
  localparam int REG_W      = 5;
  localparam int MD_ENTRY_W = REG_W + XLEN;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;

endpackage

// File: rtl/wb_md_fifo.sv
// wb_md_fifo: DEPTH-entry FIFO of {rd, data} mul/div results.
// Ports:
//   clk, rst          clock, asynchronous active-high reset (empties the FIFO)
//   push, push_data   write one entry (ignored when full unless popping too)
//   pop               remove the head entry (ignored when empty)
//   head              current head entry, valid while !empty
//   full, empty       occupancy flags, decoded from the pointers only
module wb_md_fifo import rv32_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [MD_ENTRY_W-1:0] push_data,
  input  logic                  pop,
  output logic [MD_ENTRY_W-1:0] head,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [AW:0]           wr_ptr_r;
  logic [AW:0]           rd_ptr_r;
  logic [MD_ENTRY_W-1:0] mem_r [DEPTH];
  logic                  push_ok_s;
  logic                  pop_ok_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_ok_s  = pop && !empty;
  // When full, a push is only safe because the head slot is freed in the same edge.
  assign push_ok_s = push && (!full || pop_ok_s);
  assign head      = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update; reset flushes all entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Entry storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback stage of the RV32IM pipeline.
// Registers MEM results (with load alignment/extension), merges buffered
// mul/div results into the single register-file write port, tracks
// destinations still awaiting a mul/div result, and requests a decode
// bubble when a buffered result has waited too long.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   mem_*                            MEM-stage instruction and its results
//   md_issue, md_issue_rd            decode issued a mul/div to this rd
//   md_valid, md_rd, md_result       mul/div result offer; md_ready accepts
//   reg_write, rd_wb, wd             register-file write port (registered)
//   md_pending                       bit i set while xi awaits a mul/div result
//   wb_stall                         ask decode for one bubble (registered)
module wb_stage import rv32_pkg::*; #(
  parameter int MD_DEPTH     = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_reg_write,
  input  logic        mem_memtoreg,
  input  logic [2:0]  mem_funct3,
  input  logic [1:0]  mem_addr_lo,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_load_data,
  input  logic        md_issue,
  input  logic [4:0]  md_issue_rd,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_result,
  output logic        md_ready,
  output logic        reg_write,
  output logic [4:0]  rd_wb,
  output logic [31:0] wd,
  output logic [31:0] md_pending,
  output logic        wb_stall
);

  localparam int AGE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic                  pipe_wr_s;
  logic [7:0]            byte_s;
  logic [15:0]           half_s;
  logic [31:0]           load_data_s;
  logic [31:0]           pipe_data_s;
  logic                  md_push_s;
  logic                  md_pop_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [MD_ENTRY_W-1:0] head_s;
  logic [4:0]            head_rd_s;
  logic [31:0]           head_data_s;
  logic [31:0]           set_mask_s;
  logic [31:0]           clr_mask_s;
  logic [AGE_W-1:0]      age_next_s;

  logic                  reg_write_r;
  logic [4:0]            rd_wb_r;
  logic [31:0]           wd_r;
  logic [31:0]           md_pending_r;
  logic                  wb_stall_r;
  logic [AGE_W-1:0]      age_r;

  assign pipe_wr_s   = mem_valid && mem_reg_write && (mem_rd != 5'd0);
  // rd = 0 results are acknowledged but dropped on the floor.
  assign md_push_s   = md_valid && !fifo_full_s && (md_rd != 5'd0);
  // Pipeline writes always win the port; the buffer drains in gaps.
  assign md_pop_s    = !pipe_wr_s && !fifo_empty_s;
  assign md_ready    = !fifo_full_s;
  assign head_rd_s   = head_s[MD_ENTRY_W-1:XLEN];
  assign head_data_s = head_s[XLEN-1:0];

  assign reg_write   = reg_write_r;
  assign rd_wb       = rd_wb_r;
  assign wd          = wd_r;
  assign md_pending  = md_pending_r;
  assign wb_stall    = wb_stall_r;

  wb_md_fifo #(.DEPTH(MD_DEPTH)) u_md_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (md_push_s),
    .push_data ({md_rd, md_result}),
    .pop       (md_pop_s),
    .head      (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Load alignment and extension; misaligned LH uses the addr[1] halfword.
  always_comb begin
    byte_s      = 8'h00;
    load_data_s = mem_load_data;
    pipe_data_s = mem_alu_result;
    case (mem_addr_lo)
      2'b00:   byte_s = mem_load_data[7:0];
      2'b01:   byte_s = mem_load_data[15:8];
      2'b10:   byte_s = mem_load_data[23:16];
      2'b11:   byte_s = mem_load_data[31:24];
      default: byte_s = mem_load_data[7:0];
    endcase
    if (mem_addr_lo[1]) begin
      half_s = mem_load_data[31:16];
    end else begin
      half_s = mem_load_data[15:0];
    end
    case (load_f3_e'(mem_funct3))
      F3_LB:   load_data_s = {{24{byte_s[7]}}, byte_s};
      F3_LH:   load_data_s = {{16{half_s[15]}}, half_s};
      F3_LBU:  load_data_s = {24'h000000, byte_s};
      F3_LHU:  load_data_s = {16'h0000, half_s};
      default: load_data_s = mem_load_data;
    endcase
    if (mem_memtoreg) begin
      pipe_data_s = load_data_s;
    end else begin
      pipe_data_s = mem_alu_result;
    end
  end

  // Scoreboard masks and head-entry age; age saturates at the stall threshold.
  always_comb begin
    set_mask_s = 32'h0000_0000;
    clr_mask_s = 32'h0000_0000;
    age_next_s = '0;
    if (md_issue && (md_issue_rd != 5'd0)) begin
      set_mask_s = 32'h0000_0001 << md_issue_rd;
    end else begin
      set_mask_s = 32'h0000_0000;
    end
    if (md_pop_s) begin
      clr_mask_s = 32'h0000_0001 << head_rd_s;
    end else begin
      clr_mask_s = 32'h0000_0000;
    end
    if (fifo_empty_s || md_pop_s) begin
      age_next_s = '0;
    end else if (age_r >= AGE_W'(STARVE_LIMIT)) begin
      age_next_s = age_r;
    end else begin
      age_next_s = age_r + AGE_W'(1);
    end
  end

  // Write-port arbitration, scoreboard and starvation state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_r  <= 1'b0;
      rd_wb_r      <= 5'd0;
      wd_r         <= 32'h0000_0000;
      md_pending_r <= 32'h0000_0000;
      wb_stall_r   <= 1'b0;
      age_r        <= '0;
    end else begin
      if (pipe_wr_s) begin
        reg_write_r <= 1'b1;
        rd_wb_r     <= mem_rd;
        wd_r        <= pipe_data_s;
      end else if (md_pop_s) begin
        reg_write_r <= 1'b1;
        rd_wb_r     <= head_rd_s;
        wd_r        <= head_data_s;
      end else begin
        reg_write_r <= 1'b0;
      end
      // Applying the set after the clear makes a same-cycle re-issue win.
      md_pending_r <= (md_pending_r & ~clr_mask_s) | set_mask_s;
      age_r        <= age_next_s;
      wb_stall_r   <= (age_next_s >= AGE_W'(STARVE_LIMIT));
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed and randomized checks of wb_stage against a
// queue-based reference model of the writeback rules.
module tb_wb_stage;

  localparam int DEPTH = 2;
  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_reg_write, mem_memtoreg;
  logic [2:0]  mem_funct3;
  logic [1:0]  mem_addr_lo;
  logic [4:0]  mem_rd;
  logic [31:0] mem_alu_result, mem_load_data;
  logic        md_issue;
  logic [4:0]  md_issue_rd;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_result;
  logic        md_ready, reg_write, wb_stall;
  logic [4:0]  rd_wb;
  logic [31:0] wd, md_pending;

  wb_stage #(.MD_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_memtoreg(mem_memtoreg),
    .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo), .mem_rd(mem_rd),
    .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
    .md_issue(md_issue), .md_issue_rd(md_issue_rd),
    .md_valid(md_valid), .md_rd(md_rd), .md_result(md_result), .md_ready(md_ready),
    .reg_write(reg_write), .rd_wb(rd_wb), .wd(wd),
    .md_pending(md_pending), .wb_stall(wb_stall)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [36:0] q[$];
  int          m_age;
  logic [31:0] m_pend;
  logic        m_rw;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;
  logic        m_stall;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] d);
    logic [31:0] b32, h32;
    b32 = (d >> (8 * a)) & 32'hFF;
    h32 = (d >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b32 >= 32'h80) ? (b32 - 32'h100) : b32;
      3'b001:  return (h32 >= 32'h8000) ? (h32 - 32'h10000) : h32;
      3'b100:  return b32;
      3'b101:  return h32;
      default: return d;
    endcase
  endfunction

  task automatic idle();
    mem_valid = 1'b0; mem_reg_write = 1'b0; mem_memtoreg = 1'b0;
    mem_funct3 = 3'b010; mem_addr_lo = 2'b00; mem_rd = 5'd0;
    mem_alu_result = 32'h0; mem_load_data = 32'h0;
    md_issue = 1'b0; md_issue_rd = 5'd0;
    md_valid = 1'b0; md_rd = 5'd0; md_result = 32'h0;
  endtask

  task automatic check_outputs();
    check_eq("reg_write", {31'd0, reg_write}, {31'd0, m_rw});
    check_eq("rd_wb", {27'd0, rd_wb}, {27'd0, m_rd});
    check_eq("wd", wd, m_wd);
    check_eq("md_pending", md_pending, m_pend);
    check_eq("wb_stall", {31'd0, wb_stall}, {31'd0, m_stall});
  endtask

  // One clock: model predicts from the current inputs, DUT is sampled 1 after the edge.
  task automatic step();
    logic        elig, ready, push, pop;
    logic [31:0] clr_m, set_m;
    logic [36:0] hd;
    int          age_n;
    ready = (q.size() < DEPTH);
    check_eq("md_ready", {31'd0, md_ready}, {31'd0, ready});
    elig  = mem_valid && mem_reg_write && (mem_rd != 5'd0);
    push  = md_valid && ready && (md_rd != 5'd0);
    pop   = !elig && (q.size() > 0);
    hd    = (q.size() > 0) ? q[0] : 37'd0;
    @(posedge clk);
    #1;
    if (elig) begin
      m_rw = 1'b1; m_rd = mem_rd;
      m_wd = mem_memtoreg ? ref_load(mem_funct3, mem_addr_lo, mem_load_data) : mem_alu_result;
    end else if (pop) begin
      m_rw = 1'b1; m_rd = hd[36:32]; m_wd = hd[31:0];
    end else begin
      m_rw = 1'b0;
    end
    clr_m  = pop ? (32'h1 << hd[36:32]) : 32'h0;
    set_m  = (md_issue && md_issue_rd != 5'd0) ? (32'h1 << md_issue_rd) : 32'h0;
    m_pend = (m_pend & ~clr_m) | set_m;
    age_n  = (q.size() == 0 || pop) ? 0 : m_age + 1;
    m_age  = age_n;
    m_stall = (age_n >= LIMIT);
    if (pop) void'(q.pop_front());
    if (push) q.push_back({md_rd, md_result});
    check_outputs();
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    q.delete();
    m_age = 0; m_pend = 32'h0; m_rw = 1'b0; m_rd = 5'd0; m_wd = 32'h0; m_stall = 1'b0;
    check_outputs();
    check_eq("rst_md_ready", {31'd0, md_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic pipe_write(input logic [4:0] rd, input logic [31:0] val);
    mem_valid = 1'b1; mem_reg_write = 1'b1; mem_memtoreg = 1'b0;
    mem_rd = rd; mem_alu_result = val;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    #2;
    do_reset();

    // Byte loads from the top byte, signed then unsigned
    idle();
    mem_valid = 1'b1; mem_reg_write = 1'b1; mem_memtoreg = 1'b1;
    mem_funct3 = 3'b000; mem_addr_lo = 2'b11; mem_rd = 5'd5; mem_load_data = 32'h80FF_7F01;
    step();
    check_eq("lb_wd", wd, 32'hFFFF_FF80);
    check_eq("lb_rd", {27'd0, rd_wb}, 32'd5);
    mem_funct3 = 3'b100;
    step();
    check_eq("lbu_wd", wd, 32'h0000_0080);

    // Write to x0 is suppressed
    idle();
    pipe_write(5'd0, 32'h1234);
    step();
    check_eq("x0_reg_write", {31'd0, reg_write}, 32'd0);

    // Scoreboard set on issue, cleared when the result is written
    idle();
    md_issue = 1'b1; md_issue_rd = 5'd9;
    step();
    check_eq("pend9_set", {31'd0, md_pending[9]}, 32'd1);
    idle();
    md_valid = 1'b1; md_rd = 5'd9; md_result = 32'h2A;
    step();
    check_eq("pend9_wait", {31'd0, md_pending[9]}, 32'd1);
    idle();
    step();
    check_eq("x9_write", wd, 32'h2A);
    check_eq("pend9_clr", {31'd0, md_pending[9]}, 32'd0);

    // Fill the buffer under continuous pipeline writes until starvation
    idle();
    pipe_write(5'd10, 32'hA0);
    md_valid = 1'b1; md_rd = 5'd3; md_result = 32'h333;
    step();
    md_rd = 5'd4; md_result = 32'h444;
    step();
    md_valid = 1'b0;
    check_eq("full_md_ready", {31'd0, md_ready}, 32'd0);
    step();
    step();
    check_eq("starve_stall", {31'd0, wb_stall}, 32'd1);
    idle();
    step();
    check_eq("bubble_rd", {27'd0, rd_wb}, 32'd3);
    check_eq("bubble_wd", wd, 32'h333);
    check_eq("bubble_ready", {31'd0, md_ready}, 32'd1);
    step();

    // Re-issue of x7 in the same cycle its old result pops
    idle();
    md_valid = 1'b1; md_rd = 5'd7; md_result = 32'h77;
    step();
    idle();
    md_issue = 1'b1; md_issue_rd = 5'd7;
    step();
    check_eq("reissue_rd", {27'd0, rd_wb}, 32'd7);
    check_eq("reissue_pend7", {31'd0, md_pending[7]}, 32'd1);

    // Reset with two buffered entries
    idle();
    pipe_write(5'd11, 32'hB0);
    md_valid = 1'b1; md_rd = 5'd12; md_result = 32'hC0;
    step();
    md_rd = 5'd13;
    step();
    idle();
    do_reset();

    // Randomized traffic; decode honours wb_stall with a bubble
    for (int i = 0; i < 600; i++) begin
      mem_valid      = m_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
      mem_reg_write  = ($urandom_range(0, 3) != 0);
      mem_memtoreg   = 1'($urandom);
      mem_funct3     = 3'($urandom);
      mem_addr_lo    = 2'($urandom);
      mem_rd         = 5'($urandom);
      mem_alu_result = $urandom;
      mem_load_data  = $urandom;
      md_issue       = ($urandom_range(0, 3) == 0);
      md_issue_rd    = 5'($urandom);
      md_valid       = 1'($urandom);
      md_rd          = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      md_result      = $urandom;
      step();
      if (i == 300) begin
        idle();
        do_reset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
